instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Upstream control stage for the datapath (ALU + 16-entry register file).
//  - Fetches 16-bit instructions from program memory over a req/ack handshake.
//  - Presents each instruction as Opcode/Cin for one execute cycle, with a write strobe.
//  - Captures the returned ALU Flags into a program status register (Psr).
//  - Sequences the program through a small FSM.
// PARAMETERS
//  ADDR_WIDTH  16      program counter / MemAddr width
//  RESET_PC    0       PC value loaded on reset
//  FLAG_WIDTH  5       width of Flags/Psr; bit 0 is carry
// PORTS
//  Clk       in   1           system clock, rising edge
//  Reset     in   1           asynchronous, active-low reset
//  Run       in   1           1 = keep fetching; 0 = stop at next instruction boundary
//  MemReq    out  1           fetch request to program memory
//  MemAddr   out  ADDR_WIDTH  fetch address (= PC), stable while MemReq=1
//  MemAck    in   1           memory ack; MemData valid in the same cycle
//  MemData   in   16          instruction word
//  Opcode    out  16          instruction presented to datapath ([15:12],[7:4] op, [11:8] A/dest, [3:0] B)
//  Cin       out  1           carry in to ALU (= Psr[0])
//  WrEn      out  1           register-file write strobe, 1 only in EXEC
//  Flags     in   FLAG_WIDTH  ALU flags from datapath
//  Psr       out  FLAG_WIDTH  latched flags
//  Halted    out  1           1 once a HALT instruction has executed
// BEHAVIOUR
//  - Reset (Reset=0, async):
//    - state=IDLE, PC=RESET_PC, IR=16'h0000.
//    - Outputs: MemReq=0, WrEn=0, Psr=0, Cin=0, Halted=0, Opcode=16'h0000.
//  - All outputs are registered.
//  - FSM states: IDLE, FETCH, EXEC, HALT.
//    - IDLE:  Run=1 -> FETCH; else stay.
//    - FETCH: MemReq=1, MemAddr=PC.
//      - Each edge with MemAck=1: IR<=MemData, PC<=PC+1, -> EXEC.
//      - MemAck=0: stay; MemReq and MemAddr are held unchanged.
//    - EXEC: exactly one cycle.
//      - Opcode=IR, WrEn=1.
//      - At the closing edge, Psr<=Flags.
//      - IR=16'hFFFF -> HALT, with WrEn=0 and Psr unchanged.
//      - Otherwise: Run=1 -> FETCH; Run=0 -> IDLE.
//    - HALT: Halted=1, MemReq=0, WrEn=0; exit only by Reset.
//  - MemAck outside FETCH is ignored.
//  - Run falling during FETCH: the fetch completes and executes; no abort.
//  - Minimum instruction period: 2 cycles (FETCH acked in its first cycle, then EXEC).
//  - PC wraps from 2^ADDR_WIDTH-1 to 0 without a flag.
//  - Opcode holds IR outside EXEC, so the datapath sees stable inputs; WrEn=0 blocks writes.
//  - Cin always reflects Psr[0], i.e. the carry from the previous executed instruction.
// CONFIGURATION
//  - Macro SEQ_SINGLE_STEP_EN.
//  - Defined:
//    - Extra input Step (1 bit).
//    - After every non-HALT EXEC the FSM goes to IDLE regardless of Run.
//    - IDLE -> FETCH only on a rising edge of Step, detected from a registered copy of Step.
//    - Run is ignored.
//  - Undefined: no Step port; Run behaves as above.
// TESTING
//  - Reset: hold Reset=0, then release with Run=0 -> MemReq=0, WrEn=0, Psr=0, Halted=0, MemAddr=0; FSM stays IDLE.
//  - Single fetch/exec: Run=1, MemAck=1 on first FETCH cycle, MemData=16'h1203 -> next cycle Opcode=16'h1203 and WrEn=1 for exactly 1 cycle; MemAddr then 1.
//  - Wait states: hold MemAck=0 for 3 cycles -> MemReq=1, MemAddr constant for 4 cycles, ack on the 4th; no WrEn until the cycle after ack.
//  - Flags/carry: drive Flags=5'b00001 during EXEC -> Psr=5'b00001 and Cin=1 while the next instruction is presented.
//  - HALT and wrap: MemData=16'hFFFF -> Halted=1, WrEn stays 0, MemReq stays 0 forever. Separately, PC=16'hFFFF fetch -> next MemAddr=16'h0000.
//  - Reset mid-FETCH: assert Reset while MemReq=1 -> MemReq=0 immediately (async), PC=RESET_PC.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words over req/ack, presents them to the datapath
// for one execute cycle, and latches the returned ALU flags. Optional macro: SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FLAG_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_data,
  output logic [15:0]           opcode,
  output logic                  cin,
  output logic                  wr_en,
  input  logic [FLAG_WIDTH-1:0] flags,
  output logic [FLAG_WIDTH-1:0] psr,
  output logic                  halted
);

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [15:0]             ir_q, ir_d;
  logic [FLAG_WIDTH-1:0]   psr_q, psr_d;
  logic                    start_fetch;
  logic                    keep_going;

`ifdef SEQ_SINGLE_STEP_EN
  // Each Step pulse releases exactly one instruction; Run has no effect in this build.
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign start_fetch = step & ~step_q;
  assign keep_going  = 1'b0;
`else
  assign start_fetch = run;
  assign keep_going  = run;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
    case (state_q)
      IDLE: begin
        if (start_fetch) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ir_q == HALT_WORD) begin
          state_d = HALT;
        end else begin
          psr_d   = flags;
          state_d = keep_going ? FETCH : IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are computed from the next state so every output comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      psr_q   <= '0;
      mem_req <= 1'b0;
      wr_en   <= 1'b0;
      halted  <= 1'b0;
      cin     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
      mem_req <= (state_d == FETCH);
      wr_en   <= (state_d == EXEC) && (ir_d != HALT_WORD);
      halted  <= (state_d == HALT);
      cin     <= psr_d[0];
    end
  end

  assign mem_addr = pc_q;
  assign opcode   = ir_q;
  assign psr      = psr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed steps plus randomized traffic, checked against a
// transaction-level model of fetch/execute behaviour kept inside the bench.
module tb_instr_sequencer;

  localparam logic [15:0] TB_RESET_PC = 16'hFFF8;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] opcode;
  logic        cin;
  logic        wr_en;
  logic [4:0]  flags;
  logic [4:0]  psr;
  logic        halted;

  int vectors;
  int miscompares;

  // Model: what the sequencer is doing and the architectural registers it holds.
  bit          mFetching;
  bit          mExecuting;
  bit          mHalted;
  logic [15:0] mPc;
  logic [15:0] mIr;
  logic [4:0]  mPsr;

  instr_sequencer #(
    .ADDR_WIDTH(16),
    .RESET_PC  (TB_RESET_PC),
    .FLAG_WIDTH(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_data(mem_data),
    .opcode  (opcode),
    .cin     (cin),
    .wr_en   (wr_en),
    .flags   (flags),
    .psr     (psr),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mFetching  = 0;
    mExecuting = 0;
    mHalted    = 0;
    mPc        = TB_RESET_PC;
    mIr        = 16'h0000;
    mPsr       = 5'd0;
  endtask

  task automatic modelStep();
    if (mHalted) begin
    end else if (mExecuting) begin
      mExecuting = 0;
      if (mIr == 16'hFFFF) begin
        mHalted = 1;
      end else begin
        mPsr      = flags;
        mFetching = run;
      end
    end else if (mFetching) begin
      if (mem_ack) begin
        mIr        = mem_data;
        mPc        = mPc + 16'd1;
        mFetching  = 0;
        mExecuting = 1;
      end
    end else begin
      mFetching = run;
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkField("mem_req",  32'(mem_req),  32'(mFetching));
    checkField("mem_addr", 32'(mem_addr), 32'(mPc));
    checkField("opcode",   32'(opcode),   32'(mIr));
    checkField("wr_en",    32'(wr_en),    32'(mExecuting && (mIr != 16'hFFFF)));
    checkField("cin",      32'(cin),      32'(mPsr[0]));
    checkField("psr",      32'(psr),      32'(mPsr));
    checkField("halted",   32'(halted),   32'(mHalted));
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic [15:0] d, input logic [4:0] f);
    @(negedge clk);
    run      = r;
    mem_ack  = a;
    mem_data = d;
    flags    = f;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF) w = 16'h0000;
    return w;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b1;
    run      = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    flags    = 5'd0;
    modelReset();

    // Asynchronous reset before any clock edge has seen it.
    #2 rst_n = 1'b0;
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;
    applyStimulus(0, 1, 16'h5555, 5'h1F);
    applyStimulus(0, 0, 16'h0000, 5'd0);
    checkField("idle_addr", 32'(mem_addr), 32'(TB_RESET_PC));

    // Single fetch acked on its first cycle, then one execute cycle.
    applyStimulus(1, 0, 16'h0000, 5'd0);
    checkField("fetch_req", 32'(mem_req), 32'd1);
    applyStimulus(1, 1, 16'h1203, 5'd0);
    checkField("exec_opcode", 32'(opcode), 32'h1203);
    checkField("exec_wren",   32'(wr_en),  32'd1);

    // Carry captured at the end of EXEC, while a fetch with three wait states follows.
    applyStimulus(1, 0, 16'h0000, 5'b00001);
    checkField("carry_psr", 32'(psr), 32'h01);
    applyStimulus(1, 0, 16'h0000, 5'd0);
    applyStimulus(1, 0, 16'h0000, 5'd0);
    applyStimulus(1, 0, 16'h0000, 5'd0);
    checkField("wait_wren", 32'(wr_en), 32'd0);
    applyStimulus(1, 1, 16'h2345, 5'd0);
    checkField("carry_cin", 32'(cin), 32'd1);
    applyStimulus(0, 0, 16'h0000, 5'd0);
    applyStimulus(0, 0, 16'h0000, 5'd0);

    // Run through the top of the address space until the PC wraps.
    for (int i = 0; i < 40 && mPc != 16'h0000; i++)
      applyStimulus(1, 1, randWord(), 5'($urandom));
    checkField("wrap_addr", 32'(mem_addr), 32'h0000);

    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, randWord(), 5'($urandom));

    // Reset in the middle of an outstanding fetch.
    for (int i = 0; i < 20 && !mFetching; i++)
      applyStimulus(1, 0, 16'h0000, 5'd0);
    checkField("pre_reset_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, randWord(), 5'($urandom));

    // HALT word: no write strobe, then parked regardless of Run/MemAck.
    for (int i = 0; i < 20 && !mFetching; i++)
      applyStimulus(1, 0, 16'h0000, 5'd0);
    applyStimulus(1, 1, 16'hFFFF, 5'h1F);
    checkField("halt_exec_wren", 32'(wr_en), 32'd0);
    applyStimulus(1, 1, 16'h0000, 5'h1E);
    checkField("halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, randWord(), 5'($urandom));
    checkField("halt_req", 32'(mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
